// File: rtl/neo_bitwd0_pkg.sv
// Shared types for the BITWD0 writer: FSM states, register-select codes and
// the queued request record.
package neo_bitwd0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bw_state_t;

  localparam logic SEL_BNK = 1'b1;
  localparam logic SEL_OUT = 1'b0;

  localparam int unsigned REQ_W = 7;

  typedef struct packed {
    logic       sel;
    logic [5:0] data;
  } bw_req_t;

  // Bank writes only carry three bits; the upper data lines are driven low.
  function automatic logic [5:0] bus_data(input bw_req_t r);
    return (r.sel == SEL_BNK) ? {3'b000, r.data[2:0]} : r.data;
  endfunction

endpackage

// File: rtl/neo_req_fifo.sv
// Synchronous request FIFO; push is ignored while full, pop while empty,
// and a simultaneous push/pop leaves the occupancy unchanged.
module neo_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/neo_bitwd0_writer.sv
// BITWD0 bus initiator: queues register writes and plays each as
// setup / active-low strobe / hold, keeping shadows of the latched values.
module neo_bitwd0_writer
  import neo_bitwd0_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_SEL,
  input  logic [5:0] REQ_DATA,
  output logic       M68K_ADDR_A4,
  output logic [5:0] M68K_DATA,
  output logic       nBITWD0,
  output logic       DATA_OE,
  output logic       BUSY,
  output logic [2:0] SHADOW_BNK,
  output logic [5:0] SHADOW_OUT
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  bw_state_t        state_q;
  logic [3:0]       cnt_q;
  logic             a4_q, nbit_q, oe_q;
  logic [5:0]       data_q, out_q;
  logic [2:0]       bnk_q;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, cnt_done;
  logic [REQ_W-1:0] fifo_rdata;
  bw_req_t          head;

  assign head      = bw_req_t'(fifo_rdata);
  assign fifo_push = REQ_VALID && !fifo_full;
  assign cnt_done  = (cnt_q == '0);
  // Pop exactly on the edges where the FSM loads the head into the bus registers.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) || (state_q == ST_HOLD && cnt_done));

  neo_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk_i   (CLK_24M),
    .rst_i   (RESET),
    .push_i  (fifo_push),
    .wdata_i ({REQ_SEL, REQ_DATA}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a4_q    <= 1'b0;
      data_q  <= '0;
      nbit_q  <= 1'b1;
      oe_q    <= 1'b0;
      bnk_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            a4_q    <= head.sel;
            data_q  <= bus_data(head);
            oe_q    <= 1'b1;
            cnt_q   <= SETUP_LD;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            nbit_q  <= 1'b0;
            cnt_q   <= STROBE_LD;
            state_q <= ST_STROBE;
            if (a4_q == SEL_BNK) bnk_q <= data_q[2:0];
            else                 out_q <= data_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_done) begin
            nbit_q  <= 1'b1;
            cnt_q   <= HOLD_LD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            if (!fifo_empty) begin
              a4_q    <= head.sel;
              data_q  <= bus_data(head);
              cnt_q   <= SETUP_LD;
              state_q <= ST_SETUP;
            end else begin
              oe_q    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign REQ_READY    = !fifo_full;
  assign BUSY         = (state_q != ST_IDLE) || !fifo_empty;
  assign M68K_ADDR_A4 = a4_q;
  assign M68K_DATA    = data_q;
  assign nBITWD0      = nbit_q;
  assign DATA_OE      = oe_q;
  assign SHADOW_BNK   = bnk_q;
  assign SHADOW_OUT   = out_q;

endmodule

// File: tb/tb_neo_bitwd0_writer.sv
// Bench for neo_bitwd0_writer: default-timing instance plus a 1/1/1 instance,
// scoreboarded at every strobe falling edge.
module tb_neo_bitwd0_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, sel0 = 1'b0;
  logic [5:0] data0 = '0;
  logic       rdy0, a40, nb0, oe0, busy0;
  logic [5:0] d0, sout0;
  logic [2:0] bnk0;

  logic       v1 = 1'b0, sel1 = 1'b0;
  logic [5:0] data1 = '0;
  logic       rdy1, a41, nb1, oe1, busy1;
  logic [5:0] d1, sout1;
  logic [2:0] bnk1;

  neo_bitwd0_writer u0 (
    .CLK_24M(clk), .RESET(rst), .REQ_VALID(v0), .REQ_READY(rdy0),
    .REQ_SEL(sel0), .REQ_DATA(data0), .M68K_ADDR_A4(a40), .M68K_DATA(d0),
    .nBITWD0(nb0), .DATA_OE(oe0), .BUSY(busy0), .SHADOW_BNK(bnk0), .SHADOW_OUT(sout0)
  );

  neo_bitwd0_writer #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .FIFO_DEPTH(4)
  ) u1 (
    .CLK_24M(clk), .RESET(rst), .REQ_VALID(v1), .REQ_READY(rdy1),
    .REQ_SEL(sel1), .REQ_DATA(data1), .M68K_ADDR_A4(a41), .M68K_DATA(d1),
    .nBITWD0(nb1), .DATA_OE(oe1), .BUSY(busy1), .SHADOW_BNK(bnk1), .SHADOW_OUT(sout1)
  );

  int unsigned nrun = 0, nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder model: latches on the strobe falling edge, zeroed by reset.
  logic [2:0] p_bnk;
  logic [5:0] p_out;
  always @(negedge nb0 or posedge rst) begin
    if (rst) begin
      p_bnk <= '0;
      p_out <= '0;
    end else if (a40) p_bnk <= d0[2:0];
    else              p_out <= d0;
  end

  logic [6:0]  sb0[$], sb1[$];
  int unsigned fall_q0[$], fall_q1[$];
  int unsigned cyc0 = 0, cyc1 = 0;
  logic        prev_nb0 = 1'b1, prev_nb1 = 1'b1;
  logic [6:0]  e0, e1, prevbus1 = '0, held1 = '0;

  always @(negedge clk) begin
    cyc0++;
    if (!rst && prev_nb0 && !nb0) begin
      fall_q0.push_back(cyc0);
      check("sb0_pending", sb0.size() > 0, 1'b1);
      if (sb0.size() > 0) begin
        e0 = sb0.pop_front();
        check("sb0_bus", {a40, d0}, e0);
        if (e0[6]) check("sb0_bnk_shadow", bnk0, e0[2:0]);
        else       check("sb0_out_shadow", sout0, e0[5:0]);
      end
    end
    prev_nb0 = nb0;
  end

  // Second instance also checks A4/DATA stability from the cycle before the
  // fall through the cycle after the rise.
  always @(negedge clk) begin
    cyc1++;
    if (!rst) begin
      if (prev_nb1 && !nb1) begin
        fall_q1.push_back(cyc1);
        check("stab_pre_fall", {a41, d1}, prevbus1);
        held1 = {a41, d1};
        check("sb1_pending", sb1.size() > 0, 1'b1);
        if (sb1.size() > 0) begin
          e1 = sb1.pop_front();
          check("sb1_bus", {a41, d1}, e1);
          if (e1[6]) check("sb1_bnk_shadow", bnk1, e1[2:0]);
          else       check("sb1_out_shadow", sout1, e1[5:0]);
        end
      end else if (!nb1) begin
        check("stab_low", {a41, d1}, held1);
      end else if (!prev_nb1) begin
        check("stab_post_rise", {a41, d1}, held1);
      end
    end
    prevbus1 = {a41, d1};
    prev_nb1 = nb1;
  end

  function automatic logic [6:0] exp_bus(input logic s, input logic [5:0] d);
    return {s, s ? {3'b000, d[2:0]} : d};
  endfunction

  // Both push tasks expect to be called just after a falling clock edge.
  task automatic push0(input logic s, input logic [5:0] d);
    int unsigned k = 0;
    v0 = 1'b1; sel0 = s; data0 = d;
    while (!rdy0 && k < 200) begin @(negedge clk); k++; end
    if (!rdy0) check("push0_ready_timeout", rdy0, 1'b1);
    else begin
      @(posedge clk);
      sb0.push_back(exp_bus(s, d));
      @(negedge clk);
    end
  endtask

  task automatic push1(input logic s, input logic [5:0] d);
    int unsigned k = 0;
    v1 = 1'b1; sel1 = s; data1 = d;
    while (!rdy1 && k < 200) begin @(negedge clk); k++; end
    if (!rdy1) check("push1_ready_timeout", rdy1, 1'b1);
    else begin
      @(posedge clk);
      sb1.push_back(exp_bus(s, d));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle0();
    for (int unsigned k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy0) break;
    end
    check("idle0_timeout", busy0, 1'b0);
  endtask

  task automatic wait_idle1();
    for (int unsigned k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    check("idle1_timeout", busy1, 1'b0);
  endtask

  typedef struct {
    logic       sel;
    logic [5:0] data;
    logic       exp_a4;
    logic [5:0] exp_data;
    logic [2:0] exp_bnk;
    logic [5:0] exp_out;
  } vec_t;

  vec_t        tbl[6];
  logic [11:0] nbv, oev;
  logic        bsel[5];
  logic [5:0]  bdat[5];
  int unsigned oe_gaps, nf;

  initial begin
    tbl[0] = '{1'b1, 6'h05, 1'b1, 6'h05, 3'd5, 6'h00};
    tbl[1] = '{1'b0, 6'h2A, 1'b0, 6'h2A, 3'd5, 6'h2A};
    tbl[2] = '{1'b1, 6'h3F, 1'b1, 6'h07, 3'd7, 6'h2A};
    tbl[3] = '{1'b0, 6'h15, 1'b0, 6'h15, 3'd7, 6'h15};
    tbl[4] = '{1'b1, 6'h08, 1'b1, 6'h00, 3'd0, 6'h15};
    tbl[5] = '{1'b0, 6'h00, 1'b0, 6'h00, 3'd0, 6'h00};
    bsel = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bdat = '{6'h03, 6'h11, 6'h26, 6'h3C, 6'h07};

    repeat (3) @(negedge clk);
    check("reset_state0", {nb0, a40, d0, oe0, busy0, rdy0, bnk0, sout0},
          {1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 3'h0, 6'h00});
    check("reset_state1", {nb1, a41, d1, oe1, busy1, rdy1, bnk1, sout1},
          {1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 3'h0, 6'h00});
    rst = 1'b0;
    @(negedge clk);

    for (int unsigned i = 0; i < 6; i++) begin
      push0(tbl[i].sel, tbl[i].data);
      v0 = 1'b0;
      wait_idle0();
      check($sformatf("tbl%0d_a4", i), a40, tbl[i].exp_a4);
      check($sformatf("tbl%0d_data", i), d0, tbl[i].exp_data);
      check($sformatf("tbl%0d_oe_nb", i), {oe0, nb0}, 2'b01);
      check($sformatf("tbl%0d_shadows", i), {bnk0, sout0}, {tbl[i].exp_bnk, tbl[i].exp_out});
      check($sformatf("tbl%0d_responder", i), {p_bnk, p_out}, {tbl[i].exp_bnk, tbl[i].exp_out});
    end

    // Single bank write with exact edge timing relative to the accept edge.
    v0 = 1'b1; sel0 = 1'b1; data0 = 6'h05;
    @(posedge clk);
    sb0.push_back(exp_bus(1'b1, 6'h05));
    #1 v0 = 1'b0;
    for (int unsigned k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      nbv[k-1] = nb0;
      oev[k-1] = oe0;
    end
    check("timing_nb", nbv, 12'hFC3);
    check("timing_oe", oev, 12'h0FF);
    wait_idle0();
    check("single_bnk", bnk0, 3'b101);
    check("single_out_unchanged", sout0, 6'h00);

    // Burst of five with REQ_VALID held high.
    fall_q0.delete();
    for (int unsigned i = 0; i < 5; i++) push0(bsel[i], bdat[i]);
    check("burst_ready_full", rdy0, 1'b0);
    v0 = 1'b0;
    oe_gaps = 0;
    for (int unsigned k = 0; k < 400; k++) begin
      if (fall_q0.size() > 0 && fall_q0.size() < 5 && !oe0) oe_gaps++;
      if (!busy0) break;
      @(negedge clk);
    end
    check("burst_idle", busy0, 1'b0);
    check("burst_no_idle_gap", oe_gaps, 0);
    check("burst_falls", fall_q0.size(), 5);
    for (int unsigned i = 1; i < fall_q0.size(); i++)
      check($sformatf("burst_gap%0d", i), fall_q0[i] - fall_q0[i-1], 8);
    check("burst_sb_drained", sb0.size(), 0);

    // Reset in the middle of a strobe.
    nf = fall_q0.size();
    push0(1'b1, 6'h02);
    push0(1'b0, 6'h19);
    v0 = 1'b0;
    for (int unsigned k = 0; k < 50; k++) begin
      if (fall_q0.size() > nf) break;
      @(negedge clk);
    end
    check("rst_strobe_seen", nb0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_nb", nb0, 1'b1);
    check("rst_shadows", {bnk0, sout0}, 9'h000);
    check("rst_responder", {p_bnk, p_out}, 9'h000);
    sb0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_busy", {rdy0, busy0}, 2'b10);
    nf = fall_q0.size();
    repeat (40) @(negedge clk);
    check("rst_no_strobe", fall_q0.size(), nf);
    check("rst_idle_bus", {nb0, oe0, a40, d0}, {1'b1, 1'b0, 1'b0, 6'h00});

    // 1/1/1 instance: push and pop on the same edge at occupancy full-1.
    fall_q1.delete();
    for (int unsigned i = 0; i < 6; i++) begin
      push1(i[0], 6'(6'h21 + i * 7));
      if (i == 4) check("ff_push_pop_ready", rdy1, 1'b1);
      if (i == 5) check("ff_full_after", rdy1, 1'b0);
    end
    v1 = 1'b0;
    wait_idle1();
    check("ff_falls", fall_q1.size(), 6);
    for (int unsigned i = 1; i < fall_q1.size(); i++)
      check($sformatf("ff_gap%0d", i), fall_q1[i] - fall_q1[i-1], 3);
    check("ff_sb_drained", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
